keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Synthesizable model of a 4x4 matrix keypad for self-test of the keypad scanning path. It is the responder side of the row/column interface: it watches the active-low column scan driven by the scanner and drives the active-low row lines back, as a real key closure would. A press request, given as a key code, is played out with optional contact bounce, a hold time and a release gap. Lets the full digit-entry and multiplier path run on hardware or in simulation without a physical keypad.

## Interface

Parameters:
- `HOLD_CYCLES`, default 5400000: stable-closed time, 200 ms at 27 MHz; must be ≥1.
- `RELEASE_CYCLES`, default 2700000: stable-open gap after bounce-out, 100 ms; must be ≥1.
- `BOUNCE_PERIOD`, default 27000: cycles per bounce toggle, 1 ms; must be ≥1.
- `BOUNCE_TOGGLES`, default 4: toggles per bounce phase; 0 disables both bounce phases.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `columna_i` input 4: column scan from the scanner, active-low; bit c low means column c is driven.
- `key_code_i` input 4: key to press; row r = key_code_i[3:2], column c = key_code_i[1:0].
- `press_valid_i` input 1: press request.
- `press_ready_o` output 1: emulator is idle and can accept a request.
- `key_in_o` output 4: row lines to the scanner, active-low.
- `busy_o` output 1: a press sequence is in progress.
- `done_o` output 1: one-cycle pulse when a sequence completes.

## Operation

- **Handshake**
  - A request is accepted on the rising edge where `press_valid_i & press_ready_o` is 1.
  - `key_code_i` is latched into the row and column registers on that edge.
  - `press_ready_o` = (state == IDLE). Requests made while not ready are ignored, not queued.

- **State machine.** States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, RELEASE.
  - IDLE → BOUNCE_IN on accept. If BOUNCE_TOGGLES = 0, go straight to HOLD.
  - BOUNCE_IN
    - The contact starts closed and inverts every BOUNCE_PERIOD cycles.
    - It lasts BOUNCE_PERIOD*BOUNCE_TOGGLES cycles, then → HOLD.
  - HOLD: contact forced closed for HOLD_CYCLES cycles, then → BOUNCE_OUT, or → RELEASE if BOUNCE_TOGGLES = 0.
  - BOUNCE_OUT: contact starts open, inverts every BOUNCE_PERIOD cycles, lasts BOUNCE_PERIOD*BOUNCE_TOGGLES cycles, then → RELEASE.
  - RELEASE: contact forced open for RELEASE_CYCLES cycles, then → IDLE with `done_o` = 1 for one cycle.

- **Counters**
  - One phase counter and one toggle counter.
  - Width is $clog2(max+1) of the largest value each must hold; no wrap is possible within legal parameters.
  - Both counters clear on every state change.

- **Row drive** (registered)
  - Next `key_in_o` = ~(4'b0001 << r) when the contact is closed and columna_i[c] = 0.
  - Otherwise next `key_in_o` = 4'b1111.
  - Other low bits of `columna_i` are ignored, so a multi-column scan still produces only row r.
  - `columna_i` = 4'b1111 always gives 4'b1111.
  - Only one row is ever driven low.

- `busy_o` = (state != IDLE).

## Timing

- **Reset values:** state IDLE, `key_in_o` = 4'b1111, `press_ready_o` = 1, `busy_o` = 0, `done_o` = 0, counters 0, contact open.
- **Reset mid-sequence:** aborts on the reset edge. The next cycle shows `key_in_o` = 4'b1111 and `press_ready_o` = 1, with no `done_o` pulse.
- **Accept at edge T:**
  - `busy_o` = 1 and `press_ready_o` = 0 from T+1.
  - The contact is closed from T+1.
  - `key_in_o` reflects a closure at T+2 (one register stage after `columna_i` sampling).
- **Row drive latency:** `key_in_o` follows any `columna_i` change with exactly 1 cycle of latency.
- **Sequence length:** `done_o` pulses at T+1+N, where N = 2*BOUNCE_PERIOD*BOUNCE_TOGGLES + HOLD_CYCLES + RELEASE_CYCLES.
- **Back-to-back requests:**
  - `press_ready_o` rises in the same cycle as `done_o`.
  - A request held high is accepted on that edge, so there is zero idle cycles between sequences.
  - A new sequence always follows at least RELEASE_CYCLES of open contact.
- **Code stability:** a `key_code_i` change after accept has no effect until the next accept.

## Test plan

Unless noted: HOLD_CYCLES=8, RELEASE_CYCLES=4, BOUNCE_PERIOD=2, BOUNCE_TOGGLES=0.

1. **Reset values:** hold `rst`=1 for 3 cycles, `columna_i`=4'b1110 → `key_in_o`=4'b1111, `press_ready_o`=1, `busy_o`=0, `done_o`=0.
2. **Single press, no bounce:** `key_code_i`=4'h6 (row 1, col 2), `columna_i` held at 4'b1011, accept at T.
   - `key_in_o`=4'b1101 from T+2 through T+9, then 4'b1111.
   - `done_o` pulses at T+13.
3. **Column scan:** same press, but rotate `columna_i` through 1110, 1101, 1011, 0111 each cycle.
   - `key_in_o`=4'b1101 only in the cycle after 1011 was presented; 4'b1111 otherwise.
4. **Bounce:** BOUNCE_TOGGLES=3, code 4'h0, `columna_i`=4'b1110.
   - After accept, the row 0 bit follows closed,closed,open,open,closed,closed, then holds low for 8 cycles.
   - It then follows open,open,closed,closed,open,open, then stays high.
   - `done_o` pulses at T+25.
5. **Back-to-back and ignored requests:** hold `press_valid_i`=1 with codes 4'hF then 4'h5.
   - The second request is accepted in the `done_o` cycle.
   - Requests made while `busy_o`=1 are dropped.
   - Row 3 is driven during the first sequence and row 1 during the second.
6. **Reset mid-HOLD:** assert `rst` while row 0 is driven low → `key_in_o`=4'b1111 on the next cycle, no `done_o`, `press_ready_o`=1.

Source files
------------

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 active-low row/column keypad.
// Plays out one key press as bounce-in, hold, bounce-out and release phases.
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 5400000,
  parameter int RELEASE_CYCLES = 2700000,
  parameter int BOUNCE_PERIOD  = 27000,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] columna_i,
  input  logic [3:0] key_code_i,
  input  logic       press_valid_i,
  output logic       press_ready_o,
  output logic [3:0] key_in_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] dbg_state
);

  localparam int PHASE_MAX_HR = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int PHASE_MAX    = (PHASE_MAX_HR > BOUNCE_PERIOD) ? PHASE_MAX_HR : BOUNCE_PERIOD;
  localparam int PHASE_W      = $clog2(PHASE_MAX + 1);
  localparam int TOG_W        = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
  localparam bit NO_BOUNCE    = (BOUNCE_TOGGLES == 0);

  localparam logic [PHASE_W-1:0] HOLD_LAST    = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] RELEASE_LAST = PHASE_W'(RELEASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PERIOD_LAST  = PHASE_W'(BOUNCE_PERIOD - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST     = TOG_W'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_BOUNCE_IN  = 3'd1,
    S_HOLD       = 3'd2,
    S_BOUNCE_OUT = 3'd3,
    S_RELEASE    = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase_cnt;
  logic [TOG_W-1:0]   toggle_cnt;
  logic [1:0]         row;
  logic [1:0]         col;
  logic               accept;
  logic               contact_closed;
  logic               period_end;
  logic               toggle_last;

  // Handshake: a request transfers on the rising edge where press_valid_i and
  // press_ready_o are both 1; ready is high only in IDLE, and a request seen
  // while not ready is dropped rather than held for later.
  assign accept      = press_valid_i & press_ready_o;
  assign period_end  = (phase_cnt == PERIOD_LAST);
  assign toggle_last = (toggle_cnt == TOG_LAST);
  assign dbg_state   = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = NO_BOUNCE ? S_HOLD : S_BOUNCE_IN;
        end
      end
      S_BOUNCE_IN: begin
        if (period_end && toggle_last) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (phase_cnt == HOLD_LAST) begin
          state_next = NO_BOUNCE ? S_RELEASE : S_BOUNCE_OUT;
        end
      end
      S_BOUNCE_OUT: begin
        if (period_end && toggle_last) begin
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (phase_cnt == RELEASE_LAST) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic; bounce phases alternate the contact once per toggle count.
  always_comb begin
    press_ready_o  = (state == S_IDLE);
    busy_o         = (state != S_IDLE);
    contact_closed = 1'b0;
    case (state)
      S_BOUNCE_IN:  contact_closed = ~toggle_cnt[0];
      S_HOLD:       contact_closed = 1'b1;
      S_BOUNCE_OUT: contact_closed = toggle_cnt[0];
      default:      contact_closed = 1'b0;
    endcase
  end

  // Phase and toggle counters restart at every state change.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state)) begin
      phase_cnt  <= '0;
      toggle_cnt <= '0;
    end else if ((state == S_BOUNCE_IN) || (state == S_BOUNCE_OUT)) begin
      if (period_end) begin
        phase_cnt  <= '0;
        toggle_cnt <= toggle_cnt + 1'b1;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end else if ((state == S_HOLD) || (state == S_RELEASE)) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= 2'd0;
      col <= 2'd0;
    end else if (accept) begin
      row <= key_code_i[3:2];
      col <= key_code_i[1:0];
    end
  end

  // Only the latched column matters, so a multi-column scan still drives one row.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_in_o <= 4'b1111;
      done_o   <= 1'b0;
    end else begin
      key_in_o <= (contact_closed && !columna_i[col]) ? ~(4'b0001 << row) : 4'b1111;
      done_o   <= (state == S_RELEASE) && (state_next == S_IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: two instances (no bounce / 3 toggles)
// share stimulus; expected per-cycle outputs are queued and compared.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] columna_i = 4'b1111;
  logic [3:0] key_code_i = 4'h0;
  logic       press_valid_i = 1'b0;
  logic       sel = 1'b0;

  logic       nb_ready, nb_busy, nb_done;
  logic [3:0] nb_key;
  logic [2:0] nb_state;
  logic       b_ready, b_busy, b_done;
  logic [3:0] b_key;
  logic [2:0] b_state;
  logic [6:0] obs;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(8), .RELEASE_CYCLES(4), .BOUNCE_PERIOD(2), .BOUNCE_TOGGLES(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .columna_i(columna_i), .key_code_i(key_code_i),
    .press_valid_i(press_valid_i), .press_ready_o(nb_ready), .key_in_o(nb_key),
    .busy_o(nb_busy), .done_o(nb_done), .dbg_state(nb_state)
  );

  keypad_emulator #(
    .HOLD_CYCLES(8), .RELEASE_CYCLES(4), .BOUNCE_PERIOD(2), .BOUNCE_TOGGLES(3)
  ) dut_b (
    .clk(clk), .rst(rst), .columna_i(columna_i), .key_code_i(key_code_i),
    .press_valid_i(press_valid_i), .press_ready_o(b_ready), .key_in_o(b_key),
    .busy_o(b_busy), .done_o(b_done), .dbg_state(b_state)
  );

  // {ready, busy, done, key_in} of the instance under test
  assign obs = sel ? {b_ready, b_busy, b_done, b_key} : {nb_ready, nb_busy, nb_done, nb_key};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] row_pat(input logic [1:0] r);
    case (r)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] rot_col(input int e);
    case (e % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    press_valid_i = 1'b0;
    columna_i = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One press of n cycles; contact[j-1] is the expected contact level in the
  // j-th cycle after the accept edge (1 = closed). Edge e=0 is the accept edge.
  task automatic run_seq(input string name, input int n, input logic [3:0] code,
                         input logic [31:0] contact, input logic rotate,
                         input logic [3:0] col_const, input logic keep_valid,
                         input logic rand_next, input logic [3:0] next_code);
    logic [3:0] cv;
    logic [6:0] exp;
    logic [6:0] got;
    logic       closed_prev;
    check({name, "_ready_before"}, 8'(obs[6]), 8'd1);
    for (int e = 0; e <= n; e++) begin
      press_valid_i = (e == 0) ? 1'b1 : keep_valid;
      if (e == 0) key_code_i = code;
      else key_code_i = rand_next ? 4'($urandom_range(0, 15)) : next_code;
      cv = rotate ? rot_col(e) : col_const;
      columna_i = cv;
      closed_prev = (e >= 1) && contact[e-1];
      exp[3:0] = (closed_prev && !cv[code[1:0]]) ? row_pat(code[3:2]) : 4'b1111;
      exp[4] = (e == n);
      exp[5] = (e < n);
      exp[6] = (e == n);
      exp_q.push_back(exp);
      @(negedge clk);
      got = obs;
      exp = exp_q.pop_front();
      check($sformatf("%s_e%0d", name, e), 8'(got), 8'(exp));
    end
  endtask

  initial begin
    logic found;
    logic done_seen;

    // 1: reset values
    columna_i = 4'b1110;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_nb", 8'({nb_ready, nb_busy, nb_done, nb_key}), 8'h4F);
    check("reset_b", 8'({b_ready, b_busy, b_done, b_key}), 8'h4F);
    check("reset_state_nb", 8'(nb_state), 8'd0);
    check("reset_state_b", 8'(b_state), 8'd0);
    rst = 1'b0;

    // 2: single press, no bounce, code changes after accept are ignored
    do_reset();
    sel = 1'b0;
    run_seq("single", 12, 4'h6, 32'h0000_00FF, 1'b0, 4'b1011, 1'b0, 1'b1, 4'h0);

    // 3: rotating column scan
    do_reset();
    run_seq("scan", 12, 4'h6, 32'h0000_00FF, 1'b1, 4'b1111, 1'b0, 1'b1, 4'h0);

    // 4: bounce in and out
    do_reset();
    sel = 1'b1;
    run_seq("bounce", 24, 4'h0, 32'h0003_3FF3, 1'b0, 4'b1110, 1'b0, 1'b0, 4'h0);

    // 5: back-to-back with valid held, multi-column scan
    do_reset();
    sel = 1'b0;
    run_seq("b2b_first", 12, 4'hF, 32'h0000_00FF, 1'b0, 4'b0101, 1'b1, 1'b0, 4'h5);
    run_seq("b2b_second", 12, 4'h5, 32'h0000_00FF, 1'b0, 4'b0101, 1'b0, 1'b0, 4'h0);

    // 6: reset during HOLD
    do_reset();
    sel = 1'b0;
    columna_i = 4'b1110;
    key_code_i = 4'h0;
    press_valid_i = 1'b1;
    @(negedge clk);
    press_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (nb_key === 4'b1110) found = 1'b1;
    end
    check("hold_row0_seen", 8'(found), 8'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", 8'({nb_ready, nb_busy, nb_done, nb_key}), 8'h4F);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      done_seen = done_seen | nb_done;
    end
    check("no_done_after_reset", 8'(done_seen), 8'd0);
    check("idle_after_reset", 8'({nb_ready, nb_busy, nb_key}), 8'h2F);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
